// File: rtl/mesh_router_xy_pkg.sv
// Shared definitions for the XY mesh router: port indices and route/pointer helpers.
package mesh_router_xy_pkg;

    localparam int NPORTS = 5;

    typedef logic [2:0] port_t;

    localparam port_t P_LOCAL = 3'd0;
    localparam port_t P_NORTH = 3'd1;
    localparam port_t P_SOUTH = 3'd2;
    localparam port_t P_EAST  = 3'd3;
    localparam port_t P_WEST  = 3'd4;

    // X is resolved fully before Y, which keeps the mesh deadlock-free.
    function automatic port_t xy_route(input logic x_gt, input logic x_lt,
                                       input logic y_gt, input logic y_lt);
        if (x_gt)      return P_EAST;
        else if (x_lt) return P_WEST;
        else if (y_gt) return P_SOUTH;
        else if (y_lt) return P_NORTH;
        else           return P_LOCAL;
    endfunction

    function automatic port_t port_inc(input port_t p);
        return (p == P_WEST) ? P_LOCAL : p + 3'd1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit FIFO; head is visible on dout whenever the FIFO is not empty.
module router_fifo #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FLIT_W-1:0] din,
    input  logic              pop,
    output logic [FLIT_W-1:0] dout,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push && !reset) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mesh_router_xy.sv
// 5-port XY dimension-ordered mesh router tile with per-output round-robin arbitration.
module mesh_router_xy
    import mesh_router_xy_pkg::*;
#(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*FLIT_W-1:0] in_flit,
    input  logic [NPORTS-1:0]        write_in,
    output logic [NPORTS-1:0]        full_out,
    output logic [NPORTS*FLIT_W-1:0] out_flit,
    output logic [NPORTS-1:0]        write_req,
    input  logic [NPORTS-1:0]        out_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] head  [NPORTS];
    logic [CNT_W-1:0]  count [NPORTS];
    port_t             route [NPORTS];
    logic [NPORTS-1:0] grant [NPORTS];
    logic [NPORTS-1:0] empty, push, pop;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        logic [X_W-1:0]    dx;
        logic [Y_W-1:0]    dy;
        logic [NPORTS-1:0] gcol;

        // Last slot is reserved for the flit already leaving the upstream register.
        assign full_out[p] = (count[p] >= CNT_W'(DEPTH - 1));
        assign push[p]     = write_in[p] && !full_out[p];

        router_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[p]),
            .din   (in_flit[p*FLIT_W +: FLIT_W]),
            .pop   (pop[p]),
            .dout  (head[p]),
            .empty (empty[p]),
            .count (count[p])
        );

        assign dx       = head[p][FLIT_W-1 -: X_W];
        assign dy       = head[p][FLIT_W-1-X_W -: Y_W];
        assign route[p] = xy_route(dx > X_W'(MY_X), dx < X_W'(MY_X),
                                   dy > Y_W'(MY_Y), dy < Y_W'(MY_Y));

        for (genvar o = 0; o < NPORTS; o++) begin : g_col
            assign gcol[o] = grant[o][p];
        end
        assign pop[p] = |gcol;
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        logic [NPORTS-1:0] req;
        port_t             rr_q, win;
        logic              found, gnt_v, wr_q;
        logic [FLIT_W-1:0] flit_q;

        for (genvar p = 0; p < NPORTS; p++) begin : g_req
            assign req[p] = !empty[p] && (route[p] == port_t'(o));
        end

        always_comb begin
            logic [3:0] idx;
            idx   = '0;
            found = 1'b0;
            win   = P_LOCAL;
            for (int k = 0; k < NPORTS; k++) begin
                idx = 4'(rr_q) + 4'(k);
                if (idx >= 4'(NPORTS)) idx = idx - 4'(NPORTS);
                if (!found && req[idx[2:0]]) begin
                    found = 1'b1;
                    win   = idx[2:0];
                end
            end
        end

        assign gnt_v    = found && !out_full[o];
        assign grant[o] = gnt_v ? (NPORTS'(1) << win) : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                rr_q   <= P_LOCAL;
                wr_q   <= 1'b0;
                flit_q <= '0;
            end else begin
                wr_q <= gnt_v;
                if (gnt_v) begin
                    flit_q <= head[win];
                    rr_q   <= port_inc(win);
                end
            end
        end

        assign write_req[o]                  = wr_q;
        assign out_flit[o*FLIT_W +: FLIT_W] = flit_q;
    end

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy at MY=(1,1), DEPTH=4, 16-bit flits.
module tb_mesh_router_xy;

    localparam int FW = 16;
    localparam int NP = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*FW-1:0]  in_flit, out_flit;
    logic [NP-1:0]     write_in, full_out, write_req, out_full;

    mesh_router_xy #(
        .FLIT_W(16), .DEPTH(4), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_flit   (in_flit),
        .write_in  (write_in),
        .full_out  (full_out),
        .out_flit  (out_flit),
        .write_req (write_req),
        .out_full  (out_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [15:0] flit;
        int          cyc;
    } cap_t;
    cap_t caps[$];

    always @(negedge clk) begin
        for (int p = 0; p < NP; p++)
            if (write_req[p]) caps.push_back('{p, out_flit[p*FW +: FW], cyc});
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int dx, input int dy, input logic [11:0] pl);
        return {2'(dx), 2'(dy), pl};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int p, input logic [15:0] f);
        in_flit[p*FW +: FW] = f;
        write_in[p]         = 1'b1;
    endtask

    logic [15:0] expq[$];
    logic [15:0] expw[$];
    logic [15:0] expn[$];
    int          t0, wi, ni, nfull;
    logic [11:0] pl;

    initial begin
        reset    = 1'b1;
        in_flit  = '0;
        write_in = '0;
        out_full = '0;
        idle(3);
        chk("rst_write_req", write_req, 0);
        chk("rst_full_out", full_out, 0);
        chk("rst_out_flit", out_flit, 0);
        reset = 1'b0;
        idle(1);

        // Test 1: local delivery
        caps.delete();
        t0 = cyc;
        drive(0, 16'h50AB);
        @(negedge clk);
        write_in = '0;
        idle(4);
        chk("t1_count", caps.size(), 1);
        if (caps.size() >= 1) begin
            chk("t1_port", caps[0].port, 0);
            chk("t1_flit", caps[0].flit, 16'h50AB);
            chk("t1_cycle", caps[0].cyc, t0 + 2);
        end

        // Test 2: three-way contention for east
        caps.delete();
        expq = '{mk(2,1,12'h111), mk(2,1,12'h222), mk(2,1,12'h444)};
        t0 = cyc;
        drive(1, expq[0]);
        drive(2, expq[1]);
        drive(4, expq[2]);
        @(negedge clk);
        write_in = '0;
        idle(6);
        chk("t2_count", caps.size(), 3);
        for (int i = 0; i < caps.size() && i < 3; i++) begin
            chk("t2_port", caps[i].port, 3);
            chk("t2_flit", caps[i].flit, expq[i]);
            chk("t2_cycle", caps[i].cyc, t0 + 2 + i);
        end
        // pointer now at local: local, north, west
        caps.delete();
        expq = '{mk(2,1,12'h555), mk(2,1,12'h666), mk(2,1,12'h777)};
        drive(0, expq[0]);
        drive(1, expq[1]);
        drive(4, expq[2]);
        @(negedge clk);
        write_in = '0;
        idle(6);
        chk("t2r_count", caps.size(), 3);
        for (int i = 0; i < caps.size() && i < 3; i++)
            chk("t2r_flit", caps[i].flit, expq[i]);

        // Test 3: east blocked with a continuous west stream
        caps.delete();
        expq.delete();
        out_full[3] = 1'b1;
        pl = 12'h300;
        for (int i = 0; i < 10; i++) begin
            drive(4, mk(2,1,pl));
            if (!full_out[4]) begin
                expq.push_back(mk(2,1,pl));
                pl = pl + 12'd1;
            end
            @(negedge clk);
        end
        chk("t3_full_out", full_out[4], 1);
        chk("t3_accepted", expq.size(), 3);
        chk("t3_blocked", caps.size(), 0);
        out_full[3] = 1'b0;
        for (int i = 0; i < 20 && expq.size() < 8; i++) begin
            drive(4, mk(2,1,pl));
            if (!full_out[4]) begin
                expq.push_back(mk(2,1,pl));
                pl = pl + 12'd1;
            end
            @(negedge clk);
        end
        write_in = '0;
        idle(10);
        chk("t3_count", caps.size(), expq.size());
        for (int i = 0; i < caps.size() && i < expq.size(); i++)
            chk("t3_flit", caps[i].flit, expq[i]);

        // Test 4: alternating west/north stream from local
        caps.delete();
        expw.delete();
        expn.delete();
        nfull = 0;
        for (int i = 0; i < 20; i++) begin
            if (full_out[0]) nfull++;
            if (i % 2 == 0) begin
                drive(0, mk(0,1,12'h400 + 12'(i)));
                expw.push_back(mk(0,1,12'h400 + 12'(i)));
            end else begin
                drive(0, mk(1,0,12'h400 + 12'(i)));
                expn.push_back(mk(1,0,12'h400 + 12'(i)));
            end
            @(negedge clk);
        end
        write_in = '0;
        idle(6);
        chk("t4_no_backpressure", nfull, 0);
        chk("t4_count", caps.size(), 20);
        wi = 0;
        ni = 0;
        for (int i = 0; i < caps.size(); i++) begin
            if (caps[i].port == 4 && wi < 10) begin
                chk("t4_west_flit", caps[i].flit, expw[wi]);
                wi++;
            end else if (caps[i].port == 1 && ni < 10) begin
                chk("t4_north_flit", caps[i].flit, expn[ni]);
                ni++;
            end else begin
                chk("t4_port", caps[i].port, 99);
            end
        end
        chk("t4_west_n", wi, 10);
        chk("t4_north_n", ni, 10);
        if (caps.size() == 20)
            chk("t4_rate", caps[19].cyc - caps[0].cyc, 19);

        // Test 5: reset with two buffered flits and one in flight
        out_full[3] = 1'b1;
        drive(4, mk(2,1,12'h501));
        @(negedge clk);
        drive(4, mk(2,1,12'h502));
        @(negedge clk);
        write_in = '0;
        drive(0, mk(1,1,12'h5AA));
        @(negedge clk);
        write_in = '0;
        @(negedge clk);
        chk("t5_inflight", write_req[0], 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_write_req", write_req, 0);
        chk("t5_full_out", full_out, 0);
        chk("t5_out_flit", out_flit, 0);
        reset       = 1'b0;
        out_full[3] = 1'b0;
        caps.delete();
        idle(10);
        chk("t5_no_ghosts", caps.size(), 0);

        // Test 6: writes while full are dropped
        caps.delete();
        out_full[3] = 1'b1;
        expq = '{mk(2,1,12'h601), mk(2,1,12'h602), mk(2,1,12'h603)};
        for (int i = 0; i < 3; i++) begin
            drive(4, expq[i]);
            @(negedge clk);
        end
        write_in = '0;
        chk("t6_full", full_out[4], 1);
        drive(4, mk(2,1,12'h6FF));
        idle(2);
        write_in = '0;
        chk("t6_still_full", full_out[4], 1);
        out_full[3] = 1'b0;
        idle(8);
        chk("t6_drained", full_out[4], 0);
        chk("t6_count", caps.size(), 3);
        for (int i = 0; i < caps.size() && i < 3; i++)
            chk("t6_flit", caps[i].flit, expq[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
